spi_master_ctrl: RTL and testbench
==================================

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have rst, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have start, input, 1, transfer request, sampled only in IDLE.
REQ-005 SHALL have slave_sel, input, 3, target slave index, latched at acceptance.
REQ-006 SHALL have tx_data, input, 8, byte to send, latched at acceptance.
REQ-007 SHALL have miso_in, input, 1, serial data from the 8:1 MISO selector output.
REQ-008 SHALL have miso_sel, output, 3, select for the 8:1 MISO selector.
REQ-009 SHALL have cs_n, output, 8, active-low one-hot chip selects.
REQ-010 SHALL have sclk, output, 1, SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have mosi, output, 1, serial data out, MSB first.
REQ-012 SHALL have rx_data, output, 8, last received byte.
REQ-013 SHALL have busy, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, SETUP, TRANSFER, HOLD and DONE.
REQ-016 IDLE with start=1 SHALL latch slave_sel and tx_data, load the shift register and go to SETUP; start=0 stays in IDLE.
REQ-017 start in any state other than IDLE SHALL be ignored with no queuing.
REQ-018 miso_sel SHALL equal the latched slave_sel from the acceptance edge until the next acceptance, including through IDLE.
REQ-019 In SETUP, TRANSFER and HOLD, cs_n SHALL be ~(8'b1 << latched_sel); otherwise it SHALL be 8'hFF.
REQ-020 SETUP SHALL last exactly CLK_DIV cycles, with sclk=0 and mosi=tx_data[7].
REQ-021 TRANSFER SHALL produce 8 SCLK periods, each CLK_DIV cycles high then CLK_DIV cycles low (16*CLK_DIV cycles total).
REQ-022 At each SCLK rising edge, miso_in SHALL be shifted into the receive register LSB-first-in, so the first bit received becomes rx bit 7.
REQ-023 At each of SCLK falling edges 1-7, mosi SHALL advance to the next lower tx bit.
REQ-024 After the 8th falling edge, mosi SHALL hold its last value.
REQ-025 After the 8th falling edge, the block SHALL enter HOLD for CLK_DIV cycles with sclk=0 and cs_n still asserted.
REQ-026 DONE SHALL last exactly 1 cycle with done=1, cs_n=8'hFF and rx_data updated to the received byte, then go to IDLE.
REQ-027 done SHALL first be high in cycle 18*CLK_DIV+1, where cycle 0 is the acceptance cycle.
REQ-028 rx_data SHALL change only on entry to DONE or on rst.
REQ-029 With start held high continuously, the next transfer SHALL be accepted in the IDLE cycle following DONE, giving a 1-cycle gap with cs_n=8'hFF.
REQ-030 The bit counter SHALL be 3 bits plus a terminal flag; the divider counter SHALL be 8 bits and wrap to 0 at CLK_DIV-1.

Reset
REQ-031 rst=1 at a clock edge SHALL force: state IDLE, sclk=0, mosi=0, cs_n=8'hFF, busy=0, done=0, rx_data=8'h00, miso_sel=3'd0, and clear all counters.
REQ-032 rst SHALL take priority over start.
REQ-033 rst mid-transfer SHALL abort without a done pulse, and the partially received byte SHALL be discarded.

Verification
REQ-034 Reset check: assert rst 2 cycles with start=1 -> all outputs at REQ-031 values, busy stays 0.
REQ-035 Nominal transfer: CLK_DIV=2, slave_sel=3, tx_data=8'hA5, slave model returns 8'h3C -> cs_n=8'hF7 throughout; mosi sampled at rising edges = 1,0,1,0,0,1,0,1; exactly 8 sclk rising edges; done at cycle 37; rx_data=8'h3C; miso_sel=3.
REQ-036 Busy lockout: start pulsed with slave_sel=5, tx_data=8'hFF during TRANSFER of the REQ-035 transfer -> no effect; cs_n stays 8'hF7; a single done is produced.
REQ-037 Abort: rst asserted during the 5th SCLK high phase -> next cycle cs_n=8'hFF, sclk=0, busy=0; no done; rx_data=8'h00.
REQ-038 Back-to-back: start held high, CLK_DIV=1, slave_sel=7, tx_data=8'h00 then 8'hFF, slave returns 8'hFF then 8'h00 -> cs_n=8'h7F; done at cycles 19 and 39; rx_data reads 8'hFF then 8'h00; cs_n=8'hFF in cycles 19-20.
REQ-039 Select sweep: slave_sel 0..7 with CLK_DIV=3 -> cs_n low only on bit slave_sel; miso_sel tracks slave_sel; done at cycle 55 of each transfer.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master with eight one-hot chip selects and a MISO selector.
// One byte per transfer, MSB first out; the first received bit lands in rx bit 7.
// The frame is SETUP (CLK_DIV cycles), TRANSFER (8 SCLK periods),
// HOLD (CLK_DIV cycles), then a single-cycle DONE.
module spi_master_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] slave_sel,
    input  logic [7:0] tx_data,
    input  logic       miso_in,
    output logic [2:0] miso_sel,
    output logic [7:0] cs_n,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        TRANSFER = 3'd2,
        HOLD     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] div_cnt_reg;
    logic [2:0] bit_cnt_reg;
    logic       bit_last_reg;   // set at the 8th falling SCLK edge
    logic       phase_reg;      // 0 = SCLK high half, 1 = SCLK low half
    logic [7:0] tx_shift_reg;
    logic [7:0] rx_shift_reg;
    logic [7:0] rx_data_reg;
    logic [2:0] sel_reg;
    logic       mosi_reg;

    logic div_last;
    logic accept;
    logic rise_tick;
    logic fall_tick;

    assign div_last  = (div_cnt_reg == DIV_LAST);
    assign accept    = (state_reg == IDLE) && start;
    // SCLK falls at the end of each high half-period.
    assign fall_tick = (state_reg == TRANSFER) && !phase_reg && div_last;
    // SCLK rises at the end of SETUP and at the end of every low half except the last.
    assign rise_tick = ((state_reg == SETUP) && div_last) ||
                       ((state_reg == TRANSFER) && phase_reg && div_last && !bit_last_reg);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = SETUP;
            SETUP:    if (div_last) state_next = TRANSFER;
            TRANSFER: if (phase_reg && div_last && bit_last_reg) state_next = HOLD;
            HOLD:     if (div_last) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output decode from state and datapath registers
    always_comb begin
        busy     = (state_reg != IDLE);
        done     = (state_reg == DONE);
        sclk     = (state_reg == TRANSFER) && !phase_reg;
        cs_n     = 8'hFF;
        if (state_reg == SETUP || state_reg == TRANSFER || state_reg == HOLD) begin
            cs_n = ~(8'b1 << sel_reg);
        end
        mosi     = mosi_reg;
        miso_sel = sel_reg;
        rx_data  = rx_data_reg;
    end

    // Divider, bit counter and shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg  <= 8'd0;
            bit_cnt_reg  <= 3'd0;
            bit_last_reg <= 1'b0;
            phase_reg    <= 1'b0;
            tx_shift_reg <= 8'h00;
            rx_shift_reg <= 8'h00;
            rx_data_reg  <= 8'h00;
            sel_reg      <= 3'd0;
            mosi_reg     <= 1'b0;
        end else begin
            if (state_reg == IDLE || div_last) begin
                div_cnt_reg <= 8'd0;
            end else begin
                div_cnt_reg <= div_cnt_reg + 8'd1;
            end

            if (accept) begin
                phase_reg    <= 1'b0;
                bit_cnt_reg  <= 3'd0;
                bit_last_reg <= 1'b0;
                tx_shift_reg <= tx_data;
                mosi_reg     <= tx_data[7];
                sel_reg      <= slave_sel;
            end else begin
                if (state_reg == TRANSFER && div_last) begin
                    phase_reg <= ~phase_reg;
                end
                if (fall_tick) begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        bit_last_reg <= 1'b1;
                    end else begin
                        // Falling edges 1-7 present the next lower bit; the 8th leaves mosi alone.
                        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                        mosi_reg     <= tx_shift_reg[6];
                    end
                end
            end

            if (rise_tick) begin
                rx_shift_reg <= {rx_shift_reg[6:0], miso_in};
            end

            // Publish the received byte only when the frame completes.
            if (state_reg == HOLD && div_last) begin
                rx_data_reg <= rx_shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: three instances (CLK_DIV = 2, 1, 3),
// each with a mode-0 slave model returning a programmable byte.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] slave_sel = 3'd0;
    logic [7:0] tx_data = 8'h00;

    logic       start_v    [3];
    logic [7:0] slv_v      [3];
    logic       miso_v     [3];
    logic [2:0] miso_sel_v [3];
    logic [7:0] cs_n_v     [3];
    logic       sclk_v     [3];
    logic       mosi_v     [3];
    logic [7:0] rx_data_v  [3];
    logic       busy_v     [3];
    logic       done_v     [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            logic [3:0] fcnt;
            logic       csh;

            spi_master_ctrl #(.CLK_DIV(gi == 0 ? 2 : (gi == 1 ? 1 : 3))) dut (
                .clk       (clk),
                .rst       (rst),
                .start     (start_v[gi]),
                .slave_sel (slave_sel),
                .tx_data   (tx_data),
                .miso_in   (miso_v[gi]),
                .miso_sel  (miso_sel_v[gi]),
                .cs_n      (cs_n_v[gi]),
                .sclk      (sclk_v[gi]),
                .mosi      (mosi_v[gi]),
                .rx_data   (rx_data_v[gi]),
                .busy      (busy_v[gi]),
                .done      (done_v[gi])
            );

            // Slave: presents MSB first, advances on every SCLK falling edge.
            assign csh = &cs_n_v[gi];
            always @(negedge sclk_v[gi] or posedge csh) begin
                if (csh) fcnt <= 4'd0;
                else     fcnt <= fcnt + 4'd1;
            end
            assign miso_v[gi] = (fcnt < 4'd8) ? slv_v[gi][3'd7 - fcnt[2:0]] : 1'b0;
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [7:0] tx;
        logic [7:0] slv;
        logic [7:0] exp_cs;
        logic [7:0] exp_rx;
    } vec_t;

    // Run one transfer on instance 'which' and check the whole frame.
    task automatic run_xfer(input int which, input int cd, input vec_t v, input bit inject);
        int         cyc;
        int         rises;
        int         dones;
        int         done_cyc;
        int         cs_bad;
        bit         rx_changed;
        logic       prev_sclk;
        logic [7:0] mbyte;
        logic [7:0] rx0;
        @(negedge clk);
        slave_sel = v.sel;
        tx_data = v.tx;
        slv_v[which] = v.slv;
        start_v[which] = 1'b1;
        rx0 = rx_data_v[which];
        cyc = 0; rises = 0; dones = 0; done_cyc = -1; cs_bad = 0;
        rx_changed = 1'b0; prev_sclk = 1'b0; mbyte = 8'h00;
        while (cyc < 18 * cd + 6) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start_v[which] = 1'b0;
            if (inject && cyc == 10) begin
                slave_sel = 3'd5; tx_data = 8'hFF; start_v[which] = 1'b1;
            end
            if (inject && cyc == 11) start_v[which] = 1'b0;
            if (sclk_v[which] && !prev_sclk) begin
                rises++;
                mbyte = {mbyte[6:0], mosi_v[which]};
            end
            prev_sclk = sclk_v[which];
            if (done_v[which]) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("rx_data", {24'd0, rx_data_v[which]}, {24'd0, v.exp_rx});
                    chk("cs_n_in_done", {24'd0, cs_n_v[which]}, 32'h0000_00FF);
                    chk("miso_sel", {29'd0, miso_sel_v[which]}, {29'd0, v.sel});
                end
            end else if (busy_v[which] && cs_n_v[which] !== v.exp_cs) begin
                cs_bad++;
            end
            if (done_cyc < 0 && rx_data_v[which] !== rx0) rx_changed = 1'b1;
        end
        $display("xfer inst=%0d sel=%0d tx=%h rx=%h cs=%h done@%0d rises=%0d mosi=%h",
                 which, v.sel, v.tx, rx_data_v[which], v.exp_cs, done_cyc, rises, mbyte);
        chk("sclk_rises", rises, 8);
        chk("mosi_byte", {24'd0, mbyte}, {24'd0, v.tx});
        chk("done_cycle", done_cyc, 18 * cd + 1);
        chk("done_count", dones, 1);
        chk("cs_n_frame_bad_cycles", cs_bad, 0);
        chk("rx_early_change", {31'd0, rx_changed}, 0);
        chk("busy_after", {31'd0, busy_v[which]}, 0);
    endtask

    initial begin
        vec_t sweep [8];
        vec_t nom;
        int   cyc;
        int   dones;
        int   done_a;
        int   done_b;

        sweep[0] = '{sel: 3'd0, tx: 8'h01, slv: 8'h81, exp_cs: 8'hFE, exp_rx: 8'h81};
        sweep[1] = '{sel: 3'd1, tx: 8'h80, slv: 8'h7E, exp_cs: 8'hFD, exp_rx: 8'h7E};
        sweep[2] = '{sel: 3'd2, tx: 8'hC3, slv: 8'h24, exp_cs: 8'hFB, exp_rx: 8'h24};
        sweep[3] = '{sel: 3'd3, tx: 8'h5A, slv: 8'hDB, exp_cs: 8'hF7, exp_rx: 8'hDB};
        sweep[4] = '{sel: 3'd4, tx: 8'h0F, slv: 8'h55, exp_cs: 8'hEF, exp_rx: 8'h55};
        sweep[5] = '{sel: 3'd5, tx: 8'hF0, slv: 8'hAA, exp_cs: 8'hDF, exp_rx: 8'hAA};
        sweep[6] = '{sel: 3'd6, tx: 8'h96, slv: 8'h00, exp_cs: 8'hBF, exp_rx: 8'h00};
        sweep[7] = '{sel: 3'd7, tx: 8'h69, slv: 8'hFF, exp_cs: 8'h7F, exp_rx: 8'hFF};
        nom = '{sel: 3'd3, tx: 8'hA5, slv: 8'h3C, exp_cs: 8'hF7, exp_rx: 8'h3C};

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b1;
            slv_v[i] = 8'h00;
        end

        // Reset held two cycles with start high: nothing may start.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_busy", {31'd0, busy_v[0]}, 0);
        end
        chk("reset_cs_n", {24'd0, cs_n_v[0]}, 32'h0000_00FF);
        chk("reset_sclk", {31'd0, sclk_v[0]}, 0);
        chk("reset_mosi", {31'd0, mosi_v[0]}, 0);
        chk("reset_done", {31'd0, done_v[0]}, 0);
        chk("reset_rx", {24'd0, rx_data_v[0]}, 0);
        chk("reset_miso_sel", {29'd0, miso_sel_v[0]}, 0);
        chk("reset_busy_b", {31'd0, busy_v[1]}, 0);
        chk("reset_busy_c", {31'd0, busy_v[2]}, 0);
        $display("reset cs_n=%h busy=%b rx=%h", cs_n_v[0], busy_v[0], rx_data_v[0]);
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Nominal transfer, then the same with a start pulse during TRANSFER.
        run_xfer(0, 2, nom, 1'b0);
        run_xfer(0, 2, nom, 1'b1);

        // Abort during the 5th SCLK high phase (cycles 19-20 at CLK_DIV=2).
        @(negedge clk);
        slave_sel = 3'd3; tx_data = 8'hA5; slv_v[0] = 8'h3C; start_v[0] = 1'b1;
        cyc = 0; dones = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start_v[0] = 1'b0;
            if (cyc == 19) begin
                chk("abort_sclk_high", {31'd0, sclk_v[0]}, 1);
                rst = 1'b1;
            end
            if (cyc == 20) begin
                chk("abort_cs_n", {24'd0, cs_n_v[0]}, 32'h0000_00FF);
                chk("abort_sclk", {31'd0, sclk_v[0]}, 0);
                chk("abort_busy", {31'd0, busy_v[0]}, 0);
                rst = 1'b0;
            end
            if (cyc >= 20 && done_v[0]) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_rx", {24'd0, rx_data_v[0]}, 0);
        $display("abort cs_n=%h busy=%b rx=%h dones=%0d", cs_n_v[0], busy_v[0], rx_data_v[0], dones);

        // Back-to-back on CLK_DIV=1 with start held high.
        @(negedge clk);
        slave_sel = 3'd7; tx_data = 8'h00; slv_v[1] = 8'hFF; start_v[1] = 1'b1;
        cyc = 0; dones = 0; done_a = -1; done_b = -1;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) tx_data = 8'hFF;
            if (cyc == 19) slv_v[1] = 8'h00;
            if (cyc == 39) start_v[1] = 1'b0;
            if (done_v[1]) begin
                dones++;
                if (done_a < 0) begin
                    done_a = cyc;
                    chk("b2b_rx1", {24'd0, rx_data_v[1]}, 32'h0000_00FF);
                end else if (done_b < 0) begin
                    done_b = cyc;
                    chk("b2b_rx2", {24'd0, rx_data_v[1]}, 0);
                end
            end
            if (cyc == 19 || cyc == 20) chk("b2b_gap_cs_n", {24'd0, cs_n_v[1]}, 32'h0000_00FF);
            if (cyc == 10 || cyc == 30) chk("b2b_cs_n", {24'd0, cs_n_v[1]}, 32'h0000_007F);
        end
        chk("b2b_done1", done_a, 19);
        chk("b2b_done2", done_b, 39);
        chk("b2b_done_count", dones, 2);
        $display("b2b done@%0d,%0d rx=%h", done_a, done_b, rx_data_v[1]);

        // Select sweep on CLK_DIV=3.
        for (int i = 0; i < 8; i++) begin
            run_xfer(2, 3, sweep[i], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
